// File: rtl/configuration_registers_tx.sv
// Serializes one register word (address then data, LS packet first) into
// TX_DATA_WIDTH packets on a rdy/ack stream; framing matches configuration_registers_rx.
module configuration_registers_tx #(
   parameter int TX_DATA_WIDTH  = 8,
   parameter int REG_ADDR_WIDTH = 16,
   parameter int REG_DATA_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [REG_ADDR_WIDTH-1:0] register_addr,
   input  logic [REG_DATA_WIDTH-1:0] register_data,
   input  logic                      register_rdy,
   output logic                      register_ack,
   output logic [TX_DATA_WIDTH-1:0]  tx_data,
   output logic                      tx_rdy,
   input  logic                      tx_ack
);

   localparam int A    = REG_ADDR_WIDTH / TX_DATA_WIDTH;
   localparam int D    = REG_DATA_WIDTH / TX_DATA_WIDTH;
   localparam int MAXP = (A > D) ? A : D;
   localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

   localparam logic [CW-1:0] LAST_A = CW'(A - 1);
   localparam logic [CW-1:0] LAST_D = CW'(D - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SENDING_ADDR,
      ST_SENDING_DATA
   } state_t;

   state_t                    state, state_nxt;
   logic [CW-1:0]             count, count_nxt;
   logic [REG_ADDR_WIDTH-1:0] addr_buf, addr_buf_nxt;
   logic [REG_DATA_WIDTH-1:0] data_buf, data_buf_nxt;
   logic                      tx_rdy_nxt;
   logic                      register_ack_nxt;
   logic                      xfer;

   assign xfer = tx_rdy & tx_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= ST_IDLE;
         count        <= '0;
         addr_buf     <= '0;
         data_buf     <= '0;
         tx_rdy       <= 1'b0;
         register_ack <= 1'b0;
      end else begin
         state        <= state_nxt;
         count        <= count_nxt;
         addr_buf     <= addr_buf_nxt;
         data_buf     <= data_buf_nxt;
         tx_rdy       <= tx_rdy_nxt;
         register_ack <= register_ack_nxt;
      end
   end

   always_comb begin
      state_nxt        = state;
      count_nxt        = count;
      addr_buf_nxt     = addr_buf;
      data_buf_nxt     = data_buf;
      tx_rdy_nxt       = tx_rdy;
      register_ack_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (register_rdy) begin
               addr_buf_nxt     = register_addr;
               data_buf_nxt     = register_data;
               register_ack_nxt = 1'b1;
               count_nxt        = '0;
               tx_rdy_nxt       = 1'b1;
               state_nxt        = ST_SENDING_ADDR;
            end
         end
         ST_SENDING_ADDR: begin
            if (xfer) begin
               if (count == LAST_A) begin
                  count_nxt = '0;
                  state_nxt = ST_SENDING_DATA;
               end else begin
                  count_nxt = count + 1'b1;
               end
            end
         end
         ST_SENDING_DATA: begin
            if (xfer) begin
               if (count == LAST_D) begin
                  count_nxt  = '0;
                  tx_rdy_nxt = 1'b0;
                  state_nxt  = ST_IDLE;
               end else begin
                  count_nxt = count + 1'b1;
               end
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            count_nxt  = '0;
            tx_rdy_nxt = 1'b0;
         end
      endcase
   end

   // Idle shows address packet 0 (count is 0 there), keeping tx_data deterministic.
   always_comb begin
      if (state == ST_SENDING_DATA)
         tx_data = data_buf[int'(count)*TX_DATA_WIDTH +: TX_DATA_WIDTH];
      else
         tx_data = addr_buf[int'(count)*TX_DATA_WIDTH +: TX_DATA_WIDTH];
   end

endmodule

// File: doc/configuration_registers_tx.md
# configuration_registers_tx

Serializer for register traffic toward the host. It accepts one register word (address + data) on the simple rdy/ack register interface and emits it as a stream of TX_DATA_WIDTH packets on the simple rdy/ack tx interface, address first, then data, least-significant packet first. The packet order and framing match `configuration_registers_rx`, so tx output looped into rx input reproduces the original address/data word. The block sits between the register-readback/status logic and the transmit FIFO feeding the host link.

## Interface

Parameters:
- TX_DATA_WIDTH, 8: packet width on the tx side.
- REG_ADDR_WIDTH, 16: register address width; integer multiple of TX_DATA_WIDTH.
- REG_DATA_WIDTH, 16: register data width; integer multiple of TX_DATA_WIDTH.

Derived: A = REG_ADDR_WIDTH/TX_DATA_WIDTH, D = REG_DATA_WIDTH/TX_DATA_WIDTH (both ≥1).

Ports:
- clk  in  1  fpga clock; all logic on rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low (rst=0 resets).
- register_addr  in  REG_ADDR_WIDTH  address of word to send.
- register_data  in  REG_DATA_WIDTH  data of word to send.
- register_rdy  in  1  word valid; source holds addr/data stable until it samples register_ack=1.
- register_ack  out  1  one-cycle pulse: word captured.
- tx_data  out  TX_DATA_WIDTH  current packet.
- tx_rdy  out  1  tx_data valid.
- tx_ack  in  1  sink accepts tx_data; transfer occurs on an edge where tx_rdy=1 and tx_ack=1.

## Operation

- Internal: A+D packet buffer, packet counter (width max(1,$clog2(max(A,D)))), state register.
- States: ST_IDLE, ST_SENDING_ADDR, ST_SENDING_DATA.
- ST_IDLE: tx_rdy=0. On edge with register_rdy=1: capture register_addr/register_data into buffer, register_ack<=1, count<=0, tx_rdy<=1, go ST_SENDING_ADDR. register_rdy=0: stay.
- ST_SENDING_ADDR: tx_data = register_addr packet[count] (packet i = bits [(i+1)*TX_DATA_WIDTH-1 : i*TX_DATA_WIDTH]). On transfer: if count==A-1 then count<=0, go ST_SENDING_DATA; else count<=count+1. No transfer: hold everything.
- ST_SENDING_DATA: tx_data = data packet[count]. On transfer: if count==D-1 then count<=0, tx_rdy<=0, go ST_IDLE; else count<=count+1.
- register_ack is cleared the cycle after it is set; it is 1 for exactly one cycle per captured word.
- register_rdy is ignored outside ST_IDLE; register_ack stays 0 there. Changes on register_addr/register_data after capture have no effect on the word in flight.
- tx_ack while tx_rdy=0 is ignored.
- Reset (rst=0, any time, including mid-word): state<=ST_IDLE, count<=0, tx_rdy<=0, register_ack<=0, buffer<=0. Partial word is discarded, not resumed. Outputs reach reset values asynchronously; first capture is possible on the first edge after rst returns to 1.
- In ST_IDLE tx_data shows buffer address packet 0 (don't-care to the sink, but deterministic).

## Timing

- Capture latency: register_rdy sampled 1 at edge k → register_ack=1 and tx_rdy=1 during cycle k..k+1, with tx_data = address packet 0.
- Sink never stalls: A+D consecutive transfer cycles, then tx_rdy=0 for at least one cycle (ST_IDLE). Peak throughput is one word per A+D+1 cycles.
- Back-pressure: tx_data and tx_rdy are held stable while tx_rdy=1 and tx_ack=0, for any number of cycles.
- tx_rdy and register_ack are register outputs. tx_data is a mux from registers with no combinational input-to-output path.
- A source that keeps register_rdy=1 with the next word immediately after sampling register_ack gets it captured on the first ST_IDLE edge.

## Test plan

- Basic word: addr=0x1234, data=0xABCD, tx_ack tied 1 → tx_data 0x34,0x12,0xCD,0xAB on 4 consecutive cycles. register_ack is high for exactly 1 cycle, starting the cycle tx_rdy rises. Afterwards tx_rdy=0.
- Back-pressure: same word, tx_ack pattern 1,0,0,1,0,1,1 → the same 4 bytes in order, with tx_data held during ack=0 cycles. No duplicate or lost byte. tx_rdy falls after the 4th transfer.
- Back-to-back: words (0x0001,0x00FF) then (0x8000,0x5A5A) with register_rdy held and tx_ack=1 → bytes 01,00,FF,00, one idle cycle, then 00,80,5A,5A. Exactly two register_ack pulses.
- Reset mid-word: drop rst to 0 after 2 of 4 bytes of (0x1234,0xABCD) → tx_rdy and register_ack go 0 immediately. After release, word (0x0F0F,0x1111) sends 0F,0F,11,11 with no leftover bytes.
- Parameter variant REG_ADDR_WIDTH=8, REG_DATA_WIDTH=32: addr=0x42, data=0xDEADBEEF → 42,EF,BE,AD,DE.
- Loopback into configuration_registers_rx (default params), register_ack tied 1, random tx_ack back-pressure, 100 random words → every rx register_addr/register_data equals the word sent, in order.
